// File: rtl/alarm_clock_core.sv
// alarm_clock_core: prescaler, debounce, BCD time keeping, 12/24 h display and alarm ringer.
// Define BTN_REPEAT_EN to get auto-repeat pulses on held buttons in set modes.
module alarm_clock_core #(
   parameter int CLK_HZ       = 1000000,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int RING_SEC     = 60,
   parameter int ALARM_RST_H  = 7,
   parameter int REPEAT_CYC   = 250000
) (
   input  logic       CLK_1M,
   input  logic       clr,
   input  logic       enable,
   input  logic       hourMode,
   input  logic [1:0] sel,
   input  logic       madd,
   input  logic       hadd,
   input  logic       alarm_on,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       pm,
   output logic       ring
);
   localparam int PW = $clog2(CLK_HZ);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RW = $clog2(REPEAT_CYC + 1);
   localparam logic [7:0] AL_RST = 8'((ALARM_RST_H / 10) * 16 + ALARM_RST_H % 10);

   if (CLK_HZ < 2 || DEBOUNCE_CYC < 2 || RING_SEC < 1 || RING_SEC > 255 ||
       ALARM_RST_H < 0 || ALARM_RST_H > 23 || REPEAT_CYC < 1) begin : g_bad_param
      $error("alarm_clock_core: parameter out of range");
   end

   typedef enum logic {IDLE, RING} state_t;

   function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
      return (v == top) ? 8'h00 :
             (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic set_t, set_a, tick, mp, hp, match, dismiss;
   logic [1:0] raw, pulse;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0] al_min_q, al_min_d, al_hour_q, al_hour_d;
   logic [7:0] ring_cnt_q, ring_cnt_d;
   state_t state_q, state_d;
   logic [4:0] h_bin, h12;

   assign set_t = (sel == 2'd1);
   assign set_a = (sel == 2'd2);
   assign raw   = {hadd, madd};
   assign mp    = pulse[0];
   assign hp    = pulse[1];

   for (genvar g = 0; g < 2; g++) begin : g_btn
      logic [1:0] sync_q;
      logic [DW-1:0] cnt_q;
      logic level_q, pulse_q, flip, rep;
      // level flips on the DEBOUNCE_CYC-th consecutive sample that disagrees with it
      assign flip = (sync_q[1] != level_q) && (cnt_q == DW'(DEBOUNCE_CYC - 1));
`ifdef BTN_REPEAT_EN
      logic [RW-1:0] rep_q;
      assign rep = level_q && (set_t || set_a) && (rep_q == RW'(REPEAT_CYC - 1));
      always_ff @(posedge CLK_1M or posedge clr)
         if (clr) rep_q <= '0;
         else rep_q <= (!level_q || rep_q == RW'(REPEAT_CYC - 1)) ? '0 : rep_q + 1'b1;
`else
      assign rep = 1'b0;
`endif
      always_ff @(posedge CLK_1M or posedge clr)
         if (clr) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            sync_q  <= {sync_q[0], raw[g]};
            cnt_q   <= (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
            level_q <= level_q ^ flip;
            pulse_q <= (flip & sync_q[1]) | rep;
         end
      assign pulse[g] = pulse_q;
   end

   assign tick = enable && !set_t && (presc_q == PW'(CLK_HZ - 1));

   always_comb begin
      presc_d   = set_t ? '0 : !enable ? presc_q : tick ? '0 : presc_q + 1'b1;
      sec_d     = (set_t && (mp || hp)) ? 8'h00 : tick ? inc_bcd(sec_q, 8'h59) : sec_q;
      min_d     = ((set_t && mp) || (tick && sec_q == 8'h59)) ? inc_bcd(min_q, 8'h59) : min_q;
      hour_d    = ((set_t && hp) || (tick && sec_q == 8'h59 && min_q == 8'h59)) ?
                  inc_bcd(hour_q, 8'h23) : hour_q;
      al_min_d  = (set_a && mp) ? inc_bcd(al_min_q, 8'h59) : al_min_q;
      al_hour_d = (set_a && hp) ? inc_bcd(al_hour_q, 8'h23) : al_hour_q;
   end

   // compare against the next time so ring rises with the displayed match
   assign match   = tick && alarm_on && sec_d == 8'h00 && min_d == al_min_q && hour_d == al_hour_q;
   assign dismiss = !alarm_on || ((mp || hp) && !set_t && !set_a);

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      if (state_q == IDLE) begin
         if (match && !dismiss) begin
            state_d    = RING;
            ring_cnt_d = 8'(RING_SEC);
         end
      end else if (dismiss || (tick && ring_cnt_q == 8'd1)) begin
         state_d    = IDLE;
         ring_cnt_d = 8'd0;
      end else if (tick) begin
         ring_cnt_d = ring_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge CLK_1M or posedge clr)
      if (clr) begin
         presc_q    <= '0;
         sec_q      <= 8'h00;
         min_q      <= 8'h00;
         hour_q     <= 8'h00;
         al_min_q   <= 8'h00;
         al_hour_q  <= AL_RST;
         ring_cnt_q <= 8'd0;
         state_q    <= IDLE;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         al_min_q   <= al_min_d;
         al_hour_q  <= al_hour_d;
         ring_cnt_q <= ring_cnt_d;
         state_q    <= state_d;
      end

   assign h_bin    = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
   assign h12      = (h_bin == 5'd0) ? 5'd12 : (h_bin > 5'd12) ? h_bin - 5'd12 : h_bin;
   assign hour_bcd = !hourMode ? hour_q :
                     (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
   assign pm       = hourMode && (h_bin >= 5'd12);
   assign min_bcd  = min_q;
   assign sec_bcd  = sec_q;
   assign ring     = (state_q == RING);
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed self-checking bench with CLK_HZ=10, DEBOUNCE_CYC=4, RING_SEC=3.
module tb_alarm_clock_core;
   logic clk = 1'b0;
   logic clr, enable, hourMode, madd, hadd, alarm_on, pm, ring;
   logic [1:0] sel;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   int total = 0, passed = 0, fails = 0;

   always #5 clk = ~clk;

   alarm_clock_core #(
      .CLK_HZ(10), .DEBOUNCE_CYC(4), .RING_SEC(3), .ALARM_RST_H(7), .REPEAT_CYC(50)
   ) dut (
      .CLK_1M(clk), .clr(clr), .enable(enable), .hourMode(hourMode), .sel(sel),
      .madd(madd), .hadd(hadd), .alarm_on(alarm_on), .hour_bcd(hour_bcd),
      .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm), .ring(ring)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit h, input int hold);
      if (h) hadd = 1'b1;
      else madd = 1'b1;
      cyc(hold);
      hadd = 1'b0;
      madd = 1'b0;
      cyc(10);
   endtask

   task automatic wait_ring(input int lim);
      int n = 0;
      while (ring !== 1'b1 && n < lim) begin
         cyc(1);
         n++;
      end
      check("ring_wait", {7'd0, ring}, 8'h01);
   endtask

   initial begin
      clr = 1'b1; enable = 1'b0; hourMode = 1'b0; sel = 2'd0;
      madd = 1'b0; hadd = 1'b0; alarm_on = 1'b0;
      #12;
      check("rst_hour", hour_bcd, 8'h00);
      check("rst_min", min_bcd, 8'h00);
      check("rst_sec", sec_bcd, 8'h00);
      check("rst_pm", {7'd0, pm}, 8'h00);
      check("rst_ring", {7'd0, ring}, 8'h00);
      @(negedge clk);
      clr = 1'b0;
      enable = 1'b1;
      cyc(599);
      check("run_sec59", sec_bcd, 8'h59);
      check("run_min0", min_bcd, 8'h00);
      cyc(1);
      check("run_min1", min_bcd, 8'h01);
      check("run_sec0", sec_bcd, 8'h00);
      check("run_hour0", hour_bcd, 8'h00);
      sel = 2'd1;
      madd = 1'b1;
      cyc(3);
      madd = 1'b0;
      cyc(10);
      check("glitch3", min_bcd, 8'h01);
      press(1'b0, 6);
      check("glitch6", min_bcd, 8'h02);
      repeat (58) press(1'b0, 6);
      check("wrap_min", min_bcd, 8'h00);
      check("wrap_min_hour", hour_bcd, 8'h00);
      repeat (13) press(1'b1, 6);
      check("set_hour13", hour_bcd, 8'h13);
      check("set_sec0", sec_bcd, 8'h00);
      check("set_min_keep", min_bcd, 8'h00);
      hourMode = 1'b1;
      cyc(1);
      check("h12_13", hour_bcd, 8'h01);
      check("h12_13_pm", {7'd0, pm}, 8'h01);
      repeat (11) press(1'b1, 6);
      check("h12_0", hour_bcd, 8'h12);
      check("h12_0_pm", {7'd0, pm}, 8'h00);
      repeat (12) press(1'b1, 6);
      check("h12_12", hour_bcd, 8'h12);
      check("h12_12_pm", {7'd0, pm}, 8'h01);
      hourMode = 1'b0;
      cyc(1);
      check("h24_12", hour_bcd, 8'h12);
      check("h24_12_pm", {7'd0, pm}, 8'h00);
      repeat (11) press(1'b1, 6);
      repeat (59) press(1'b0, 6);
      check("set_2359_h", hour_bcd, 8'h23);
      check("set_2359_m", min_bcd, 8'h59);
      sel = 2'd0;
      cyc(590);
      check("pre_wrap_s", sec_bcd, 8'h59);
      check("pre_wrap_m", min_bcd, 8'h59);
      cyc(10);
      check("day_wrap_h", hour_bcd, 8'h00);
      check("day_wrap_m", min_bcd, 8'h00);
      check("day_wrap_s", sec_bcd, 8'h00);
      enable = 1'b0;
      sel = 2'd2;
      repeat (17) press(1'b1, 6);
      press(1'b0, 6);
      sel = 2'd0;
      alarm_on = 1'b1;
      enable = 1'b1;
      cyc(599);
      check("alarm_pre", {7'd0, ring}, 8'h00);
      check("alarm_pre_s", sec_bcd, 8'h59);
      cyc(1);
      check("alarm_ring", {7'd0, ring}, 8'h01);
      check("alarm_min", min_bcd, 8'h01);
      check("alarm_sec", sec_bcd, 8'h00);
      cyc(29);
      check("alarm_still", {7'd0, ring}, 8'h01);
      cyc(1);
      check("alarm_timeout", {7'd0, ring}, 8'h00);
      check("alarm_to_sec", sec_bcd, 8'h03);
      enable = 1'b0;
      sel = 2'd2;
      press(1'b0, 6);
      sel = 2'd0;
      enable = 1'b1;
      wait_ring(800);
      check("dis_min", min_bcd, 8'h02);
      madd = 1'b1;
      cyc(6);
      check("dis_pre", {7'd0, ring}, 8'h01);
      cyc(1);
      check("dis_ring", {7'd0, ring}, 8'h00);
      check("dis_min_keep", min_bcd, 8'h02);
      madd = 1'b0;
      cyc(10);
      enable = 1'b0;
      sel = 2'd2;
      press(1'b0, 6);
      sel = 2'd0;
      enable = 1'b1;
      wait_ring(800);
      alarm_on = 1'b0;
      cyc(1);
      check("off_ring", {7'd0, ring}, 8'h00);
      alarm_on = 1'b1;
      enable = 1'b0;
      sel = 2'd2;
      press(1'b0, 6);
      sel = 2'd0;
      enable = 1'b1;
      wait_ring(800);
      check("clr_pre_min", min_bcd, 8'h04);
      #2 clr = 1'b1;
      #1;
      check("clr_ring", {7'd0, ring}, 8'h00);
      check("clr_min", min_bcd, 8'h00);
      @(negedge clk);
      clr = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
